// File: rtl/lfsr_timer_pkg.sv
// Shared types and constants for the LFSR countdown timer.
package lfsr_timer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN,
      EXPIRE
   } state_t;

   localparam logic [15:0] DEFAULT_POLY = 16'b1101_0000_0000_1000;
   localparam int unsigned EXP_CNT_W    = 8;

endpackage

// File: rtl/lfsr_timer_ctrl_lfsr.sv
// Galois XNOR LFSR with synchronous clear; all-ones is the lock-up state.
module lfsr_timer_ctrl_lfsr
   import lfsr_timer_pkg::*;
#(
   parameter  POLY = DEFAULT_POLY,
   localparam int unsigned SIZE = $clog2(POLY)
) (
   input  logic            clock,
   input  logic            i_reset,
   input  logic            i_enable,
   output logic [SIZE-1:0] o_sreg
);

   // POLY[SIZE-1] is the implicit x^SIZE term; the remaining bits select XNOR taps.
   always_ff @(posedge clock) begin
      if (i_reset)
         o_sreg <= '0;
      else if (i_enable)
         o_sreg <= {o_sreg[0],
                    o_sreg[SIZE-1:1] ^ ({(SIZE-1){~o_sreg[0]}} & POLY[SIZE-2:0])};
   end

endmodule

// File: rtl/lfsr_timer_ctrl.sv
// Countdown timer: an LFSR steps on i_tick from zero until it reaches a latched terminal state.
module lfsr_timer_ctrl
   import lfsr_timer_pkg::*;
#(
   parameter  POLY = DEFAULT_POLY,
   localparam int unsigned SIZE = $clog2(POLY)
) (
   input  logic                 clock,
   input  logic                 i_reset,
   input  logic                 i_start_valid,
   output logic                 o_start_ready,
   input  logic [SIZE-1:0]      i_terminal,
   input  logic                 i_periodic,
   input  logic                 i_abort,
   input  logic                 i_tick,
   output logic                 o_busy,
   output logic                 o_expire,
   output logic                 o_error,
   output logic [SIZE-1:0]      o_count_state,
   output logic [EXP_CNT_W-1:0] o_expire_cnt
);

   state_t          state;
   logic [SIZE-1:0] terminal;
   logic            periodic;
   logic            match;
   logic            lfsr_clear;
   logic            lfsr_enable;

   always_comb begin
      match       = (o_count_state == terminal);
      lfsr_clear  = i_reset | (state == CLEAR);
      lfsr_enable = (state == RUN) & i_tick & ~match & ~i_abort;
   end

   lfsr_timer_ctrl_lfsr #(
      .POLY (POLY)
   ) u_lfsr (
      .clock    (clock),
      .i_reset  (lfsr_clear),
      .i_enable (lfsr_enable),
      .o_sreg   (o_count_state)
   );

   // Outputs are registered alongside the state; each transition sets the ones it changes.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state         <= IDLE;
         o_start_ready <= 1'b1;
         o_busy        <= 1'b0;
         o_expire      <= 1'b0;
         o_error       <= 1'b0;
         o_expire_cnt  <= '0;
         terminal      <= '0;
         periodic      <= 1'b0;
      end else begin
         o_error  <= 1'b0;
         o_expire <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start_valid) begin
                  terminal     <= i_terminal;
                  periodic     <= i_periodic;
                  o_expire_cnt <= '0;
                  if (&i_terminal) begin
                     o_error <= 1'b1;
                  end else begin
                     state         <= CLEAR;
                     o_start_ready <= 1'b0;
                     o_busy        <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               if (i_abort) begin
                  state         <= IDLE;
                  o_start_ready <= 1'b1;
                  o_busy        <= 1'b0;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (i_abort) begin
                  state         <= IDLE;
                  o_start_ready <= 1'b1;
                  o_busy        <= 1'b0;
               end else if (match) begin
                  state    <= EXPIRE;
                  o_expire <= 1'b1;
               end
            end
            EXPIRE: begin
               if (o_expire_cnt != '1)
                  o_expire_cnt <= o_expire_cnt + 1'b1;
               if (i_abort || !periodic) begin
                  state         <= IDLE;
                  o_start_ready <= 1'b1;
                  o_busy        <= 1'b0;
               end else begin
                  state <= CLEAR;
               end
            end
            default: begin
               state         <= IDLE;
               o_start_ready <= 1'b1;
               o_busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_timer_ctrl.sv
// Directed checks of lfsr_timer_ctrl against hand-derived LFSR sequence and timing.
module tb_lfsr_timer_ctrl;

   logic        clock;
   logic        i_reset;
   logic        i_start_valid;
   logic        o_start_ready;
   logic [15:0] i_terminal;
   logic        i_periodic;
   logic        i_abort;
   logic        i_tick;
   logic        o_busy;
   logic        o_expire;
   logic        o_error;
   logic [15:0] o_count_state;
   logic [7:0]  o_expire_cnt;

   int unsigned n_cmp;
   int unsigned n_err;
   int unsigned pulses;

   lfsr_timer_ctrl dut (
      .clock         (clock),
      .i_reset       (i_reset),
      .i_start_valid (i_start_valid),
      .o_start_ready (o_start_ready),
      .i_terminal    (i_terminal),
      .i_periodic    (i_periodic),
      .i_abort       (i_abort),
      .i_tick        (i_tick),
      .o_busy        (o_busy),
      .o_expire      (o_expire),
      .o_error       (o_error),
      .o_count_state (o_count_state),
      .o_expire_cnt  (o_expire_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt;
      @(negedge clock);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, o_start_ready, 1);
      check({tag, "_busy"},  o_busy, 0);
      check({tag, "_exp"},   o_expire, 0);
      check({tag, "_err"},   o_error, 0);
      check({tag, "_count"}, o_count_state, 0);
      check({tag, "_cnt"},   o_expire_cnt, 0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      i_reset = 1'b1; i_start_valid = 1'b1; i_terminal = 16'h1234;
      i_periodic = 1'b1; i_abort = 1'b0; i_tick = 1'b1;
      repeat (2) nxt;
      check_reset_vals("rst");

      // single tick to 0x5008, one-shot
      i_reset = 1'b0; i_start_valid = 1'b1; i_terminal = 16'h5008;
      i_periodic = 1'b0; i_tick = 1'b0;
      nxt;
      check("t1_busy", o_busy, 1);
      check("t1_ready", o_start_ready, 0);
      i_start_valid = 1'b0;
      nxt;
      check("t1_cleared", o_count_state, 16'h0000);
      i_tick = 1'b1;
      nxt;
      i_tick = 1'b0;
      check("t1_step1", o_count_state, 16'h5008);
      check("t1_noexp", o_expire, 0);
      nxt;
      check("t1_exp", o_expire, 1);
      nxt;
      check("t1_exp_end", o_expire, 0);
      check("t1_idle", o_busy, 0);
      check("t1_ready2", o_start_ready, 1);
      check("t1_cnt", o_expire_cnt, 1);
      check("t1_hold", o_count_state, 16'h5008);

      // abort in IDLE does nothing
      i_abort = 1'b1;
      nxt;
      i_abort = 1'b0;
      check("idle_abort_busy", o_busy, 0);
      check("idle_abort_count", o_count_state, 16'h5008);

      // two ticks to 0x780C with tick held high
      i_start_valid = 1'b1; i_terminal = 16'h780C; i_tick = 1'b1;
      nxt;
      i_start_valid = 1'b0;
      nxt;
      nxt;
      check("t2_step1", o_count_state, 16'h5008);
      nxt;
      check("t2_step2", o_count_state, 16'h780C);
      check("t2_noexp", o_expire, 0);
      nxt;
      check("t2_exp", o_expire, 1);
      check("t2_hold", o_count_state, 16'h780C);
      nxt;
      i_tick = 1'b0;
      check("t2_exp_end", o_expire, 0);
      check("t2_idle", o_busy, 0);
      check("t2_cnt", o_expire_cnt, 1);

      // start while busy is ignored
      i_start_valid = 1'b1; i_terminal = 16'h780C;
      nxt;
      i_terminal = 16'h0000;
      nxt;
      nxt;
      check("busy_start_noexp", o_expire, 0);
      check("busy_start_busy", o_busy, 1);
      i_start_valid = 1'b0; i_tick = 1'b1;
      nxt;
      nxt;
      i_tick = 1'b0;
      check("busy_start_count", o_count_state, 16'h780C);
      nxt;
      check("busy_start_exp", o_expire, 1);
      nxt;
      check("busy_start_idle", o_busy, 0);

      // lock-up terminal rejected
      i_start_valid = 1'b1; i_terminal = 16'hFFFF;
      nxt;
      i_start_valid = 1'b0;
      check("ff_err", o_error, 1);
      check("ff_busy", o_busy, 0);
      check("ff_ready", o_start_ready, 1);
      check("ff_cnt", o_expire_cnt, 0);
      nxt;
      check("ff_err_end", o_error, 0);
      pulses = 0;
      repeat (4) begin
         nxt;
         if (o_expire) pulses++;
      end
      check("ff_noexp", pulses, 0);
      check("ff_busy2", o_busy, 0);

      // abort in CLEAR, then ticks in IDLE are ignored
      i_start_valid = 1'b1; i_terminal = 16'h5008;
      nxt;
      i_start_valid = 1'b0; i_abort = 1'b1;
      nxt;
      i_abort = 1'b0;
      check("clr_abort_busy", o_busy, 0);
      check("clr_abort_ready", o_start_ready, 1);
      i_tick = 1'b1;
      nxt;
      nxt;
      i_tick = 1'b0;
      check("idle_tick_count", o_count_state, 16'h0000);
      check("idle_tick_noexp", o_expire, 0);

      // periodic with terminal 0: pulse every 3 cycles, saturate, abort at match
      i_start_valid = 1'b1; i_terminal = 16'h0000; i_periodic = 1'b1;
      pulses = 0;
      for (int unsigned k = 1; k <= 800; k++) begin
         nxt;
         i_start_valid = 1'b0;
         if (k <= 12) check($sformatf("per_exp_%0d", k), o_expire, (k % 3 == 0) ? 1 : 0);
         if (k == 12) check("per_cnt12", o_expire_cnt, 3);
         if (k == 764) check("per_cnt764", o_expire_cnt, 254);
         if (o_expire) pulses++;
      end
      check("per_pulses", pulses, 266);
      check("per_sat", o_expire_cnt, 255);
      i_abort = 1'b1;
      nxt;
      i_abort = 1'b0;
      check("match_abort_noexp", o_expire, 0);
      check("match_abort_idle", o_busy, 0);
      pulses = 0;
      repeat (9) begin
         nxt;
         if (o_expire) pulses++;
      end
      check("per_after_abort", pulses, 0);
      check("per_sat_hold", o_expire_cnt, 255);

      // reset mid-RUN with start request held
      i_start_valid = 1'b1; i_terminal = 16'h780C; i_periodic = 1'b1;
      nxt;
      i_start_valid = 1'b0;
      nxt;
      i_tick = 1'b1;
      nxt;
      i_tick = 1'b0;
      check("mid_count", o_count_state, 16'h5008);
      check("mid_busy", o_busy, 1);
      i_reset = 1'b1; i_start_valid = 1'b1; i_terminal = 16'h0000; i_tick = 1'b1;
      nxt;
      check_reset_vals("mrst1");
      nxt;
      check_reset_vals("mrst2");
      i_reset = 1'b0; i_start_valid = 1'b0; i_tick = 1'b0;
      nxt;
      check("post_rst_busy", o_busy, 0);
      check("post_rst_exp", o_expire, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
